// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry handshake: state encoding and default token width.
// Used by the user-panel initiator and the gate-side register manager.
package parking_pkg;

  localparam int unsigned TOKEN_W_DEFAULT = 3;
  localparam int unsigned STATE_W         = 4;

  localparam logic [STATE_W-1:0] ST_IDLE       = 4'd0;
  localparam logic [STATE_W-1:0] ST_REQ        = 4'd1;
  localparam logic [STATE_W-1:0] ST_ENTER      = 4'd2;
  localparam logic [STATE_W-1:0] ST_CONF1      = 4'd3;
  localparam logic [STATE_W-1:0] ST_GAP        = 4'd4;
  localparam logic [STATE_W-1:0] ST_CONF2      = 4'd5;
  localparam logic [STATE_W-1:0] ST_WAIT_GRANT = 4'd6;
  localparam logic [STATE_W-1:0] ST_DONE       = 4'd7;
  localparam logic [STATE_W-1:0] ST_FAIL       = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = ST_IDLE,
    S_REQ        = ST_REQ,
    S_ENTER      = ST_ENTER,
    S_CONF1      = ST_CONF1,
    S_GAP        = ST_GAP,
    S_CONF2      = ST_CONF2,
    S_WAIT_GRANT = ST_WAIT_GRANT,
    S_DONE       = ST_DONE,
    S_FAIL       = ST_FAIL
  } state_e;

  // States during which the manager must see request held high.
  function automatic logic holds_request(input state_e s);
    return s inside {S_REQ, S_ENTER, S_CONF1, S_GAP, S_CONF2, S_WAIT_GRANT};
  endfunction

endpackage

// File: rtl/parking_cycle_timer.sv
// Cycle timer with synchronous clear and enable; flags the terminal count LENGTH-1 and
// saturates there so it never wraps.
module parking_cycle_timer #(
  parameter int unsigned LENGTH = 200,
  localparam int unsigned CNT_W = (LENGTH > 2) ? $clog2(LENGTH) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  logic [CNT_W-1:0] count;

  assign terminal_c = (count == CNT_W'(LENGTH - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !terminal_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/parking_request_initiator.sv
// User-panel initiator of the parking entry handshake: holds request, captures the keyed token,
// sends two confirm pulses and waits for the manager's grant, reporting done or error.
module parking_request_initiator
  import parking_pkg::*;
#(
  parameter int unsigned TOKEN_W     = TOKEN_W_DEFAULT,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               cancel_btn,
  input  logic               key_valid,
  input  logic [TOKEN_W-1:0] key_value,
  input  logic               grant,
  input  logic               deny,
  output logic               request,
  output logic               confirm,
  output logic [TOKEN_W-1:0] user_token,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned PHASE_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  state_e             state;
  state_e             state_nxt_c;
  logic [PHASE_W-1:0] phase;
  logic               phase_last_c;
  logic               state_entry_c;
  logic               timeout_c;
  logic               abortable_c;

  // Timeout watchdog runs only while waiting on the user or on the manager.
  parking_cycle_timer #(
    .LENGTH(TIMEOUT_CYC)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (state_entry_c),
    .enable    ((state == S_ENTER) || (state == S_WAIT_GRANT)),
    .terminal_c(timeout_c)
  );

  assign state_entry_c = (state_nxt_c != state);
  assign abortable_c   = holds_request(state) && cancel_btn;
  assign phase_last_c  = (state == S_REQ) ? (phase == PHASE_W'(SETUP_CYC - 1))
                                          : (phase == PHASE_W'(GAP_CYC - 1));

  // Next-state decision; cancel outranks deny, grant, timeout and key entry.
  always_comb begin
    state_nxt_c = state;
    if (abortable_c) begin
      state_nxt_c = S_FAIL;
    end else begin
      unique case (state)
        S_IDLE:       if (start_btn) state_nxt_c = S_REQ;
        S_REQ:        if (phase_last_c) state_nxt_c = S_ENTER;
        S_ENTER: begin
          if (timeout_c)      state_nxt_c = S_FAIL;
          else if (key_valid) state_nxt_c = S_CONF1;
        end
        S_CONF1:      state_nxt_c = S_GAP;
        S_GAP: begin
          if (deny)              state_nxt_c = S_FAIL;
          else if (phase_last_c) state_nxt_c = S_CONF2;
        end
        S_CONF2:      state_nxt_c = S_WAIT_GRANT;
        S_WAIT_GRANT: begin
          if (deny)           state_nxt_c = S_FAIL;
          else if (grant)     state_nxt_c = S_DONE;
          else if (timeout_c) state_nxt_c = S_FAIL;
        end
        S_DONE:       state_nxt_c = S_IDLE;
        S_FAIL:       state_nxt_c = S_IDLE;
        default:      state_nxt_c = S_IDLE;
      endcase
    end
  end

  // State, phase counter and outputs registered together so outputs track the state exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= '0;
      request    <= 1'b0;
      confirm    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      user_token <= '0;
    end else begin
      state   <= state_nxt_c;
      request <= holds_request(state_nxt_c);
      confirm <= (state_nxt_c == S_CONF1) || (state_nxt_c == S_CONF2);
      busy    <= (state_nxt_c != S_IDLE);
      done    <= (state_nxt_c == S_DONE);
      error   <= (state_nxt_c == S_FAIL);

      if (state_entry_c) begin
        phase <= '0;
      end else if ((state == S_REQ) || (state == S_GAP)) begin
        phase <= phase + PHASE_W'(1);
      end

      if ((state == S_ENTER) && (state_nxt_c == S_CONF1)) begin
        user_token <= key_value;
      end
    end
  end

endmodule

// File: tb/tb_parking_request_initiator.sv
// Scenario bench for parking_request_initiator: each task drives one scenario, expected
// transaction outcomes go through a queue and are popped when done/error appears.
module tb_parking_request_initiator;

  localparam int unsigned TOKEN_W     = 3;
  localparam int unsigned SETUP_CYC   = 2;
  localparam int unsigned GAP_CYC     = 2;
  localparam int unsigned TIMEOUT_CYC = 200;
  localparam int          WAIT_BUDGET = 20;

  typedef struct packed {
    logic               is_done;
    logic [TOKEN_W-1:0] token;
  } outcome_t;

  logic               clock;
  logic               reset;
  logic               start_btn;
  logic               cancel_btn;
  logic               key_valid;
  logic [TOKEN_W-1:0] key_value;
  logic               grant;
  logic               deny;
  logic               request;
  logic               confirm;
  logic [TOKEN_W-1:0] user_token;
  logic               busy;
  logic               done;
  logic               error;

  outcome_t exp_q[$];
  int       n_cmp;
  int       n_err;

  parking_request_initiator #(
    .TOKEN_W    (TOKEN_W),
    .SETUP_CYC  (SETUP_CYC),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start_btn (start_btn),
    .cancel_btn(cancel_btn),
    .key_valid (key_valid),
    .key_value (key_value),
    .grant     (grant),
    .deny      (deny),
    .request   (request),
    .confirm   (confirm),
    .user_token(user_token),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start a transaction and advance to the first ENTER cycle.
  task automatic go_to_enter(input logic hold_start);
    start_btn = 1'b1;
    tick();
    if (!hold_start) start_btn = 1'b0;
    repeat (SETUP_CYC) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start_btn = 1'b0; cancel_btn = 1'b0; key_valid = 1'b0;
    key_value = '0; grant = 1'b0; deny = 1'b0;
    tick();
    n_cmp++; if (request !== 1'b0) begin n_err++; $display("FAIL reset_request: got %b want 0", request); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (confirm !== 1'b0) begin n_err++; $display("FAIL reset_confirm: got %b want 0", confirm); end
    n_cmp++; if ({done, error} !== 2'b00) begin n_err++; $display("FAIL reset_done_error: got %b want 00", {done, error}); end
    n_cmp++; if (user_token !== '0) begin n_err++; $display("FAIL reset_token: got %0d want 0", user_token); end
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_happy();
    int second;
    int w;
    outcome_t exp_o;
    start_btn = 1'b1;
    tick();
    n_cmp++; if ({request, busy} !== 2'b11) begin n_err++; $display("FAIL happy_req_rise: got %b want 11", {request, busy}); end
    start_btn = 1'b0;
    repeat (SETUP_CYC) tick();
    key_valid = 1'b1; key_value = 3'b101;
    exp_q.push_back(outcome_t'{is_done: 1'b1, token: 3'd5});
    tick();
    key_valid = 1'b0;
    n_cmp++; if (confirm !== 1'b1) begin n_err++; $display("FAIL happy_confirm1: got %b want 1", confirm); end
    n_cmp++; if (user_token !== 3'd5) begin n_err++; $display("FAIL happy_token: got %0d want 5", user_token); end
    second = 0;
    for (int i = 1; i <= 8 && second == 0; i++) begin
      tick();
      if (confirm) second = i;
    end
    n_cmp++; if (second != GAP_CYC + 1) begin n_err++; $display("FAIL happy_confirm_spacing: got %0d want %0d", second, GAP_CYC + 1); end
    // Manager grant lands three cycles after CONF2.
    repeat (3) tick();
    grant = 1'b1;
    w = 0;
    while (!(done || error) && w < WAIT_BUDGET) begin tick(); w++; end
    grant = 1'b0;
    n_cmp++; if ((done || error) !== 1'b1) begin n_err++; $display("FAIL happy_outcome_seen: got none within %0d cycles", WAIT_BUDGET); end
    n_cmp++; if (w != 1) begin n_err++; $display("FAIL happy_grant_latency: got %0d want 1", w); end
    exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : outcome_t'('1);
    n_cmp++; if ({done, user_token} !== {exp_o.is_done, exp_o.token}) begin n_err++; $display("FAIL happy_scoreboard: got done=%b tok=%0d want done=%b tok=%0d", done, user_token, exp_o.is_done, exp_o.token); end
    n_cmp++; if ({request, error} !== 2'b00) begin n_err++; $display("FAIL happy_req_fall: got req/err %b want 00", {request, error}); end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL happy_done_once: got done/busy %b want 00", {done, busy}); end
  endtask

  task automatic test_wrong_token();
    int w;
    int conf_seen;
    outcome_t exp_o;
    go_to_enter(1'b0);
    key_valid = 1'b1; key_value = 3'd3;
    exp_q.push_back(outcome_t'{is_done: 1'b0, token: 3'd3});
    tick();
    key_valid = 1'b0;
    n_cmp++; if (confirm !== 1'b1) begin n_err++; $display("FAIL deny_confirm1: got %b want 1", confirm); end
    tick();
    tick();
    deny = 1'b1;
    conf_seen = 0;
    w = 0;
    while (!(done || error) && w < WAIT_BUDGET) begin tick(); w++; if (confirm) conf_seen++; end
    deny = 1'b0;
    n_cmp++; if ((done || error) !== 1'b1) begin n_err++; $display("FAIL deny_outcome_seen: got none within %0d cycles", WAIT_BUDGET); end
    exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : outcome_t'('1);
    n_cmp++; if ({done, user_token} !== {exp_o.is_done, exp_o.token}) begin n_err++; $display("FAIL deny_scoreboard: got done=%b tok=%0d want done=%b tok=%0d", done, user_token, exp_o.is_done, exp_o.token); end
    n_cmp++; if ({error, request} !== 2'b10) begin n_err++; $display("FAIL deny_error: got err/req %b want 10", {error, request}); end
    tick();
    if (confirm) conf_seen++;
    n_cmp++; if (conf_seen != 0) begin n_err++; $display("FAIL deny_no_confirm2: got %0d confirm cycles want 0", conf_seen); end
    n_cmp++; if ({error, busy} !== 2'b00) begin n_err++; $display("FAIL deny_back_idle: got err/busy %b want 00", {error, busy}); end
  endtask

  task automatic test_timeout();
    int n;
    int conf_seen;
    go_to_enter(1'b0);
    n = 0;
    conf_seen = 0;
    while (!error && n < TIMEOUT_CYC + 50) begin
      tick();
      n++;
      if (confirm) conf_seen++;
    end
    n_cmp++; if (n != TIMEOUT_CYC) begin n_err++; $display("FAIL timeout_cycle: got %0d want %0d", n, TIMEOUT_CYC); end
    n_cmp++; if (conf_seen != 0) begin n_err++; $display("FAIL timeout_confirm: got %0d want 0", conf_seen); end
    n_cmp++; if ({error, request, done} !== 3'b100) begin n_err++; $display("FAIL timeout_outputs: got err/req/done %b want 100", {error, request, done}); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_cancel_vs_grant();
    int w;
    outcome_t exp_o;
    go_to_enter(1'b0);
    key_valid = 1'b1; key_value = 3'd6;
    exp_q.push_back(outcome_t'{is_done: 1'b0, token: 3'd6});
    tick();
    key_valid = 1'b0;
    repeat (GAP_CYC + 1) tick();
    n_cmp++; if (confirm !== 1'b1) begin n_err++; $display("FAIL cancel_confirm2: got %b want 1", confirm); end
    tick();
    grant = 1'b1; cancel_btn = 1'b1;
    w = 0;
    while (!(done || error) && w < WAIT_BUDGET) begin tick(); w++; end
    grant = 1'b0; cancel_btn = 1'b0;
    n_cmp++; if ((done || error) !== 1'b1) begin n_err++; $display("FAIL cancel_outcome_seen: got none within %0d cycles", WAIT_BUDGET); end
    exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : outcome_t'('1);
    n_cmp++; if ({done, user_token} !== {exp_o.is_done, exp_o.token}) begin n_err++; $display("FAIL cancel_scoreboard: got done=%b tok=%0d want done=%b tok=%0d", done, user_token, exp_o.is_done, exp_o.token); end
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL cancel_error: got %b want 1", error); end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL cancel_after: got done/busy %b want 00", {done, busy}); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    go_to_enter(1'b0);
    key_valid = 1'b1; key_value = 3'd2;
    tick();
    key_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({request, busy, confirm} !== 3'b000) begin n_err++; $display("FAIL rstmid_outputs: got req/busy/conf %b want 000", {request, busy, confirm}); end
    n_cmp++; if (user_token !== '0) begin n_err++; $display("FAIL rstmid_token: got %0d want 0", user_token); end
    pulses = (done || error) ? 1 : 0;
    repeat (5) begin tick(); if (done || error) pulses++; end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_no_pulse: got %0d pulses want 0", pulses); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int w;
    int lows;
    outcome_t exp_o;
    start_btn = 1'b1;
    tick();
    key_valid = 1'b1; key_value = 3'd7;
    tick();
    key_valid = 1'b0;
    repeat (SETUP_CYC - 1) tick();
    key_valid = 1'b1; key_value = 3'd1;
    exp_q.push_back(outcome_t'{is_done: 1'b1, token: 3'd1});
    tick();
    key_valid = 1'b0;
    n_cmp++; if (user_token !== 3'd1) begin n_err++; $display("FAIL b2b_token1: got %0d want 1", user_token); end
    repeat (GAP_CYC + 2) tick();
    grant = 1'b1;
    w = 0;
    while (!(done || error) && w < WAIT_BUDGET) begin tick(); w++; end
    grant = 1'b0;
    exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : outcome_t'('1);
    n_cmp++; if ({done, user_token} !== {exp_o.is_done, exp_o.token}) begin n_err++; $display("FAIL b2b_scoreboard1: got done=%b tok=%0d want done=%b tok=%0d", done, user_token, exp_o.is_done, exp_o.token); end
    // Low window is the DONE cycle plus the IDLE cycle that samples start_btn.
    lows = request ? 0 : 1;
    while (!request && lows < 10) begin tick(); if (!request) lows++; end
    n_cmp++; if (lows != 2) begin n_err++; $display("FAIL b2b_low_gap: got %0d low cycles want 2", lows); end
    repeat (SETUP_CYC - 1) tick();
    start_btn = 1'b0;
    tick();
    key_valid = 1'b1; key_value = 3'd4;
    exp_q.push_back(outcome_t'{is_done: 1'b0, token: 3'd4});
    tick();
    key_valid = 1'b0;
    n_cmp++; if (user_token !== 3'd4) begin n_err++; $display("FAIL b2b_token2: got %0d want 4", user_token); end
    repeat (GAP_CYC + 2) tick();
    deny = 1'b1;
    w = 0;
    while (!(done || error) && w < WAIT_BUDGET) begin tick(); w++; end
    deny = 1'b0;
    n_cmp++; if ((done || error) !== 1'b1) begin n_err++; $display("FAIL b2b_outcome_seen: got none within %0d cycles", WAIT_BUDGET); end
    exp_o = (exp_q.size() != 0) ? exp_q.pop_front() : outcome_t'('1);
    n_cmp++; if ({done, user_token} !== {exp_o.is_done, exp_o.token}) begin n_err++; $display("FAIL b2b_scoreboard2: got done=%b tok=%0d want done=%b tok=%0d", done, user_token, exp_o.is_done, exp_o.token); end
    tick();
    tick();
    n_cmp++; if ({busy, user_token} !== {1'b0, 3'd4}) begin n_err++; $display("FAIL b2b_token_hold: got busy=%b tok=%0d want busy=0 tok=4", busy, user_token); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_happy();
    test_wrong_token();
    test_timeout();
    test_cancel_vs_grant();
    test_reset_mid();
    test_back_to_back();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
